// File: rtl/fifo_drain_packer.sv
// Read-side drain stage for the 32-bit synchronous FIFO: a 4-entry skid buffer
// feeding a valid/ready stream framed into fixed PKT_LEN-beat packets.
module fifo_drain_packer #(
  parameter int unsigned DW      = 32,
  parameter int unsigned PKT_LEN = 4,
  parameter int unsigned CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_data,
  output logic          fifo_rd,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  output logic          m_last,
  input  logic          m_ready,
  output logic [CW-1:0] pkt_cnt,
  output logic          busy
);

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned NW    = 3;
  localparam int unsigned BW    = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  localparam logic [BW-1:0] LAST_BEAT = BW'(PKT_LEN - 1);
  localparam logic [NW-1:0] FULL_LVL  = NW'(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [NW-1:0] count;
  logic          inflight;
  logic [BW-1:0] beat;
  logic [CW-1:0] pkt_q;

  logic          push;
  logic          pop;
  logic          beat_end;
  logic [NW-1:0] committed;

  // Slots already owed: buffered words plus the word returning next cycle.
  assign committed = count + NW'(inflight);
  assign fifo_rd   = rst && en && !fifo_empty && (committed < FULL_LVL);

  assign push     = inflight;
  assign pop      = m_valid && m_ready;
  assign beat_end = (beat == LAST_BEAT);

  assign m_valid = (count != '0);
  assign m_data  = m_valid ? mem[rptr] : '0;
  assign m_last  = m_valid && beat_end;
  assign pkt_cnt = pkt_q;
  assign busy    = m_valid || inflight;

  // Storage carries no reset; a word landing during reset is never counted.
  always_ff @(posedge clk) begin
    if (rst && push) begin
      mem[wptr] <= fifo_data;
    end
  end

  // Pointers, occupancy and the in-flight read flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      inflight <= 1'b0;
    end else begin
      inflight <= fifo_rd;
      if (push) begin
        wptr <= wptr + AW'(1);
      end
      if (pop) begin
        rptr <= rptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
    end
  end

  // Packet framing moves only on accepted beats, so m_last is stall-stable.
  always_ff @(posedge clk) begin
    if (!rst) begin
      beat  <= '0;
      pkt_q <= '0;
    end else if (pop) begin
      if (beat_end) begin
        beat  <= '0;
        pkt_q <= pkt_q + CW'(1);
      end else begin
        beat  <= beat + BW'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_drain_packer.sv
// Directed bench for fifo_drain_packer: behavioural FIFO source, expected-beat
// scoreboard filled at load time, and a monitor checking every accepted beat.
module tb_fifo_drain_packer;

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        fifo_rd;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready;
  logic [15:0] pkt_cnt;
  logic        busy;

  logic [31:0] fq [$];
  exp_t        sb [$];
  int          exp_beat;
  int          rd_count;
  int          acc_count;
  int          total;
  int          bad;
  logic [15:0] exp_pkt;

  logic        have_prev;
  logic        prev_valid;
  logic        prev_ready;
  logic [31:0] prev_data;
  logic        prev_last;

  fifo_drain_packer dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .m_data     (m_data),
    .m_valid    (m_valid),
    .m_last     (m_last),
    .m_ready    (m_ready),
    .pkt_cnt    (pkt_cnt),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read FIFO model: data appears the cycle after fifo_rd.
  always @(posedge clk) begin
    if (fifo_rd && fq.size() > 0) begin
      fifo_data <= fq.pop_front();
      rd_count  = rd_count + 1;
    end
  end

  always @(negedge clk) begin
    fifo_empty <= (fq.size() == 0);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: scoreboard pops on each handshake, stall stability, packet count.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      exp_pkt   = '0;
      have_prev = 1'b0;
    end else begin
      chk("pkt_cnt_track", 32'(pkt_cnt), 32'(exp_pkt));
      if (have_prev && prev_valid && !prev_ready) begin
        chk("stall_valid", 32'(m_valid), 32'd1);
        chk("stall_data", m_data, prev_data);
        chk("stall_last", 32'(m_last), 32'(prev_last));
      end
      if (m_valid && m_ready) begin
        acc_count = acc_count + 1;
        if (sb.size() == 0) begin
          chk("unexpected_beat", m_data, 32'hffff_ffff);
        end else begin
          e = sb.pop_front();
          chk("beat_data", m_data, e.data);
          chk("beat_last", 32'(m_last), 32'(e.last));
          if (e.last) exp_pkt = exp_pkt + 16'd1;
        end
      end
      prev_valid = m_valid;
      prev_ready = m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      have_prev  = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] base, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      fq.push_back(base + 32'(i));
      e.data = base + 32'(i);
      e.last = (exp_beat == 3);
      sb.push_back(e);
      exp_beat = (exp_beat + 1) % 4;
    end
  endtask

  task automatic wait_acc(input int target, input int budget, input string nm);
    int n;
    n = 0;
    while (acc_count < target && n < budget) begin
      tick();
      n++;
    end
    if (acc_count < target) chk(nm, 32'(acc_count), 32'(target));
  endtask

  task automatic drain(input int budget, input string nm);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    if (sb.size() != 0) chk(nm, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    int a0;
    rst = 1'b0; en = 1'b1; m_ready = 1'b0;
    exp_beat = 0; rd_count = 0; acc_count = 0; total = 0; bad = 0;
    exp_pkt = '0; have_prev = 1'b0;
    prev_valid = 1'b0; prev_ready = 1'b0; prev_data = '0; prev_last = 1'b0;

    // Reset held with a non-empty FIFO, then release into streaming.
    load(32'h0, 12);
    repeat (3) begin
      tick();
      @(negedge clk);
      chk("rst_fifo_rd", 32'(fifo_rd), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    end
    tick();
    rst = 1'b1; m_ready = 1'b1;
    @(negedge clk);
    chk("release_fifo_rd", 32'(fifo_rd), 32'd1);
    chk("release_valid_t0", 32'(m_valid), 32'd0);
    @(negedge clk);
    chk("release_valid_t1", 32'(m_valid), 32'd0);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("stream_no_gap", 32'(m_valid), 32'd1);
    end
    drain(50, "stream_drain");
    @(negedge clk);
    chk("stream_pkt_cnt", 32'(pkt_cnt), 32'd3);

    // Backpressure: one beat, then ten stalled cycles.
    tick();
    a0 = acc_count;
    load(32'h10, 12);
    wait_acc(a0 + 1, 20, "bp_first_beat");
    m_ready = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    chk("bp_fifo_rd_low", 32'(fifo_rd), 32'd0);
    chk("bp_held_words", 32'(rd_count - acc_count), 32'd4);
    chk("bp_valid_held", 32'(m_valid), 32'd1);
    tick();
    m_ready = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      chk("bp_resume_no_gap", 32'(m_valid), 32'd1);
    end
    drain(50, "bp_drain");
    @(negedge clk);
    chk("bp_pkt_cnt", 32'(pkt_cnt), 32'd6);

    // Alternating ready: simultaneous push/pop and pointer wrap.
    tick();
    load(32'h100, 20);
    m_ready = 1'b0;
    for (int i = 0; i < 200 && sb.size() != 0; i++) begin
      tick();
      m_ready = ~m_ready;
    end
    if (sb.size() != 0) chk("alt_drain", 32'(sb.size()), 32'd0);
    m_ready = 1'b1;
    @(negedge clk);
    chk("alt_pkt_cnt", 32'(pkt_cnt), 32'd11);

    // en dropped after two beats of a packet, restored five cycles later.
    tick();
    a0 = acc_count;
    load(32'h200, 8);
    wait_acc(a0 + 2, 30, "en_two_beats");
    en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("en_low_no_read", 32'(fifo_rd), 32'd0);
    end
    tick();
    en = 1'b1;
    drain(50, "en_drain");
    @(negedge clk);
    chk("en_pkt_cnt", 32'(pkt_cnt), 32'd13);

    // Reset with two beats accepted and three buffered.
    tick();
    a0 = acc_count;
    load(32'h300, 5);
    wait_acc(a0 + 2, 30, "rstmid_two_beats");
    m_ready = 1'b0;
    repeat (6) tick();
    @(negedge clk);
    chk("rstmid_busy_before", 32'(busy), 32'd1);
    chk("rstmid_data_before", m_data, 32'h302);
    tick();
    rst = 1'b0;
    sb.delete();
    exp_beat = 0;
    tick();
    @(negedge clk);
    chk("rstmid_m_valid", 32'(m_valid), 32'd0);
    chk("rstmid_m_last", 32'(m_last), 32'd0);
    chk("rstmid_m_data", m_data, 32'd0);
    chk("rstmid_pkt_cnt", 32'(pkt_cnt), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_fifo_rd", 32'(fifo_rd), 32'd0);
    tick();
    rst = 1'b1;
    load(32'h400, 4);
    m_ready = 1'b1;
    drain(50, "rstmid_drain");
    @(negedge clk);
    chk("rstmid_pkt_after", 32'(pkt_cnt), 32'd1);
    chk("rstmid_idle", 32'(busy), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_drain_packer.md
# fifo_drain_packer

Downstream read-side stage for the 32-bit synchronous FIFO. It pulls words from the FIFO's registered read port and holds them in a 4-entry skid buffer. It presents them on a valid/ready stream framed into fixed-length packets, with `m_last` asserted on every `PKT_LEN`-th beat. It keeps the FIFO read rate at one word per cycle whenever the sink accepts, and never overruns its own buffer.

## Interface
- `DW`, 32: data width; must match the FIFO data width.
- `PKT_LEN`, 4: beats per packet; legal range 1..256.
- `CW`, 16: width of the completed-packet counter.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `en`  in  1  permits new FIFO reads; buffered and in-flight words still drain when low.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_data`  in  DW  FIFO read data; valid on the cycle after `fifo_rd` is asserted.
- `fifo_rd`  out  1  FIFO read strobe (combinational).
- `m_data`  out  DW  stream data; equals buffer head.
- `m_valid`  out  1  stream valid; high when the buffer is non-empty.
- `m_last`  out  1  last beat of packet; meaningful only while `m_valid` is high.
- `m_ready`  in  1  sink accept.
- `pkt_cnt`  out  CW  completed packets; wraps modulo 2^CW.
- `busy`  out  1  high when the buffer is non-empty or a read is in flight.

## Operation
- **Skid buffer**
  - 4 entries: `wptr`/`rptr` are 2 bits and wrap 3→0.
  - `count` is 0..4.
  - Push on `inflight`, where `inflight` is `fifo_rd` registered.
  - Pop on `m_valid && m_ready`.
- **Read issue:** `fifo_rd = en && !fifo_empty && (count + inflight) < 4`.
  - This guarantees every in-flight word has a free slot.
  - No push is ever dropped.
- **Simultaneous push and pop:** `count` unchanged; the head advances and the new word is written at `wptr`.
- **Beat counter `beat`**
  - Width is ceil(log2(PKT_LEN)), minimum 1.
  - Increments on each accepted beat.
  - When `beat == PKT_LEN-1` on an accepted beat, it returns to 0 and `pkt_cnt` increments.
  - With `PKT_LEN = 1`, every beat is last.
- **`m_last`:** `m_valid && beat == PKT_LEN-1`.
  - Holds steady while stalled, because `beat` only moves on acceptance.
- **Stream rule:** once `m_valid` is high, `m_data` and `m_last` hold until accepted. `m_valid` never drops without acceptance, except on reset.
- **`en` low mid-packet:** no new reads. The packet is not closed; `beat` is preserved and framing resumes when `en` returns high.
- **Reset, synchronous, `rst == 0` at an edge**
  - All state clears: `count`, `wptr`, `rptr`, `inflight`, `beat` and `pkt_cnt` go to 0.
  - A word in flight is discarded.
  - A partial packet is abandoned; the next word after reset is beat 0.
- **Output reset values:** `m_valid=0`, `m_last=0`, `m_data=0`, `pkt_cnt=0`, `busy=0`.
  - `fifo_rd` is 0 while `rst` is low, gated combinationally.
  - Buffer storage needs no reset, but `m_data` is forced to 0 when `count == 0`.

## Timing
- **Read latency:** `fifo_rd` high in cycle t → `fifo_data` valid in t+1 → captured at the t+1 edge → `m_valid` high in t+2.
- **Throughput:** with `m_ready` held high and the FIFO non-empty, `fifo_rd` stays high every cycle and one beat is accepted per cycle from t+2 onward.
- **Backpressure:** with `m_ready` low from cycle s, at most 4 words are held.
  - `fifo_rd` deasserts once `count + inflight` reaches 4.
  - No word is lost or duplicated.
- **Restart:** when `m_ready` returns high, `fifo_rd` reasserts in the same cycle that `count + inflight` drops below 4.
- **`fifo_empty`** is sampled combinationally in the cycle of issue. The FIFO updates its count on the same edge as the read, so back-to-back reads of the last word cannot occur.
- **`pkt_cnt`** updates on the edge that accepts the last beat.

## Test plan
- **Reset values:** hold `rst=0` for 3 cycles with the FIFO non-empty → `fifo_rd=0`, `m_valid=0`, `pkt_cnt=0` throughout. Release → `fifo_rd=1` in the first cycle and `m_valid=1` two cycles later.
- **Streaming:** FIFO preloaded with 0x0..0xB, `m_ready=1`, `PKT_LEN=4` → 12 beats on consecutive cycles, in order. `m_last` on data 0x3, 0x7 and 0xB; `pkt_cnt` ends at 3.
- **Backpressure:** same load, `m_ready` low for 10 cycles after the first beat → at most 4 words buffered and `fifo_rd` low after that. `m_data` is stable during the stall. The sequence resumes with no gap or duplicate.
- **Simultaneous push/pop and pointer wrap:** alternate `m_ready` 1/0 over 20 words → the pointers wrap at least 4 times and the output order matches input order.
- **`en` gating:** deassert `en` after 2 beats of a packet, then reassert 5 cycles later → in-flight words still emit. Beats 3 and 4 follow with `m_last` on beat 4 and `pkt_cnt=1`.
- **Reset mid-packet:** assert `rst` with 2 beats accepted and 3 buffered → all outputs return to reset values. The next word is beat 0, and `m_last` appears on the 4th beat after reset.
